// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin grant stage.
//   arb_state_t  : grant FSM state encoding
//   DEF_N        : default requester count (matches the ring counter width)
//   DEF_MAX_HOLD : default maximum consecutive grant cycles per owner
//   onehot_valid : true when exactly one bit of the vector is set
package rr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    localparam int DEF_N        = 4;
    localparam int DEF_MAX_HOLD = 16;
    localparam int VEC_MAX      = 64;

    // Callers zero-extend their vector to VEC_MAX bits.
    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    function automatic logic onehot_valid(input logic [VEC_MAX-1:0] vec);
        return (vec != '0) && ((vec & (vec - VEC_MAX'(1))) == '0);
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin winner selection.
//   req        in   N     request vector
//   ptr        in   N     one-hot priority pointer
//   win_onehot out  N     one-hot winner (0 when no request)
//   win_id     out  ID_W  binary index of the winner (0 when no request)
//   any        out  1     at least one request is pending
//   bad_ptr    out  1     ptr is zero or has more than one bit set
// The search starts at the pointer position and walks downward with
// wrap-around, matching the ring counter's right-rotation direction.
module rr_priority_select
    import rr_arb_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    ptr,
    output logic [N-1:0]    win_onehot,
    output logic [ID_W-1:0] win_id,
    output logic            any,
    output logic            bad_ptr
);

    int  start_idx;
    int  cand;
    logic found;

    always_comb begin
        bad_ptr = !onehot_valid(VEC_MAX'(ptr));

        // An unusable pointer falls back to the top requester.
        start_idx = N - 1;
        if (!bad_ptr) begin
            for (int i = 0; i < N; i++) begin
                if (ptr[i]) start_idx = i;
            end
        end

        win_onehot = '0;
        win_id     = '0;
        found      = 1'b0;
        cand       = 0;
        for (int k = 0; k < N; k++) begin
            cand = (start_idx - k + N) % N;
            if (!found && req[cand]) begin
                found            = 1'b1;
                win_onehot[cand] = 1'b1;
                win_id           = ID_W'(cand);
            end
        end

        any = |req;
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Grant stage of the round-robin arbiter.
//   clk        in   1     clock, rising edge
//   rst_n      in   1     asynchronous active-low reset
//   req        in   N     level requests, one bit per requester
//   ptr        in   N     one-hot priority pointer from the ring counter
//   gnt        out  N     registered one-hot grant
//   gnt_valid  out  1     high while gnt is nonzero
//   gnt_id     out  ID_W  binary index of the owner (0 when no grant)
//   timeout    out  1     one-cycle pulse when MAX_HOLD revoked a grant
//   ptr_err    out  1     one-cycle pulse when a grant was chosen with a bad ptr
// The owner keeps the grant until it drops its request or MAX_HOLD grant
// cycles have elapsed; either way one dead cycle follows before the next
// arbitration.
module rr_grant_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int ID_W     = $clog2(N),
    parameter int HOLD_W   = $clog2(MAX_HOLD) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    ptr,
    output logic [N-1:0]    gnt,
    output logic            gnt_valid,
    output logic [ID_W-1:0] gnt_id,
    output logic            timeout,
    output logic            ptr_err
);

    arb_state_t        state;
    logic [HOLD_W-1:0] hold_cnt;

    logic [N-1:0]      win_onehot;
    logic [ID_W-1:0]   win_id;
    logic              win_any;
    logic              bad_ptr;
    logic              owner_req;
    logic              hold_full;

    rr_priority_select #(
        .N    (N),
        .ID_W (ID_W)
    ) u_sel (
        .req        (req),
        .ptr        (ptr),
        .win_onehot (win_onehot),
        .win_id     (win_id),
        .any        (win_any),
        .bad_ptr    (bad_ptr)
    );

    // gnt is one-hot, so masking with it isolates the owner's request bit.
    assign owner_req = |(req & gnt);
    assign hold_full = (hold_cnt >= HOLD_W'(MAX_HOLD));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            timeout   <= 1'b0;
            ptr_err   <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            timeout <= 1'b0;
            ptr_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_any) begin
                        state     <= GRANT;
                        gnt       <= win_onehot;
                        gnt_id    <= win_id;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= HOLD_W'(1);
                        ptr_err   <= bad_ptr;
                    end
                end
                GRANT: begin
                    // A normal release outranks a coincident timeout.
                    if (!owner_req || hold_full) begin
                        state     <= RELEASE;
                        gnt       <= '0;
                        gnt_id    <= '0;
                        gnt_valid <= 1'b0;
                        hold_cnt  <= '0;
                        timeout   <= owner_req;
                    end else begin
                        hold_cnt  <= hold_cnt + HOLD_W'(1);
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    gnt       <= '0;
                    gnt_id    <= '0;
                    gnt_valid <= 1'b0;
                    hold_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
module tb_rr_grant_arbiter;
    localparam int N  = 4;
    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] ptr;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_id;
    logic       timeout;
    logic       ptr_err;

    always #5 clk = ~clk;

    rr_grant_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .ptr       (ptr),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .timeout   (timeout),
        .ptr_err   (ptr_err)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model: phase 0 = idle, 1 = granted, 2 = dead cycle.
    int m_phase, m_owner, m_cnt;
    bit m_to, m_bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input logic [3:0] p);
        int s;
        s = N - 1;
        if ($countones(p) == 1)
            for (int i = 0; i < N; i++) if (p[i]) s = i;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (s - k + N) % N;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_owner = 0; m_cnt = 0; m_to = 0; m_bad = 0;
    endtask

    task automatic model_step();
        case (m_phase)
            0: if (req != 4'b0) begin
                m_owner = pick(req, ptr);
                m_bad   = ($countones(ptr) != 1);
                m_phase = 1;
                m_cnt   = 1;
            end
            1: if (!req[m_owner]) begin
                m_phase = 2; m_to = 0;
            end else if (m_cnt == MH) begin
                m_phase = 2; m_to = 1;
            end else begin
                m_cnt++;
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic compare_all();
        logic [3:0] eg;
        eg = (m_phase == 1) ? 4'(1 << m_owner) : 4'b0;
        chk("gnt",       32'(gnt),       32'(eg));
        chk("gnt_valid", 32'(gnt_valid), 32'(m_phase == 1));
        chk("gnt_id",    32'(gnt_id),    (m_phase == 1) ? 32'(m_owner) : 32'd0);
        chk("timeout",   32'(timeout),   32'(m_phase == 2 && m_to));
        chk("ptr_err",   32'(ptr_err),   32'(m_phase == 1 && m_cnt == 1 && m_bad));
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b1111;
        ptr   = 4'b1000;
        model_reset();

        // Reset holds everything low regardless of requests.
        repeat (3) begin
            cyc();
            chk("rst_gnt", 32'(gnt), 32'd0);
            chk("rst_flags", 32'({gnt_valid, timeout, ptr_err, gnt_id}), 32'd0);
        end
        rst_n = 1'b1;
        cyc();
        chk("t1_gnt", 32'(gnt), 32'h8);
        req = 4'b0;
        cyc(); cyc();

        // Plain selection and wrap-around selection.
        ptr = 4'b0100; req = 4'b1011;
        cyc();
        chk("t2_gnt", 32'(gnt), 32'h2);
        chk("t2_id",  32'(gnt_id), 32'd1);
        req = 4'b0; cyc(); cyc();
        ptr = 4'b0001; req = 4'b1100;
        cyc();
        chk("t2w_gnt", 32'(gnt), 32'h8);
        chk("t2w_id",  32'(gnt_id), 32'd3);
        req = 4'b0; cyc(); cyc();

        // Owner 1 holds for three cycles then releases.
        ptr = 4'b0010; req = 4'b0010;
        repeat (3) begin
            cyc();
            chk("t3_gnt", 32'(gnt), 32'h2);
        end
        req = 4'b0;
        cyc();
        chk("t3_rel_gnt", 32'(gnt), 32'd0);
        chk("t3_rel_to",  32'(timeout), 32'd0);
        cyc();

        // Hold timeout with MAX_HOLD = 4, then re-grant.
        ptr = 4'b0100; req = 4'b0100;
        repeat (4) begin
            cyc();
            chk("t4_gnt", 32'(gnt), 32'h4);
        end
        cyc();
        chk("t4_to",  32'(timeout), 32'd1);
        chk("t4_gnt0", 32'(gnt), 32'd0);
        cyc();
        chk("t4_to_off", 32'(timeout), 32'd0);
        cyc();
        chk("t4_regnt", 32'(gnt), 32'h4);
        req = 4'b0; cyc(); cyc();

        // Invalid pointers.
        ptr = 4'b0000; req = 4'b0001;
        cyc();
        chk("t5a_gnt", 32'(gnt), 32'h1);
        chk("t5a_err", 32'(ptr_err), 32'd1);
        cyc();
        chk("t5a_err_off", 32'(ptr_err), 32'd0);
        req = 4'b0; cyc(); cyc();
        ptr = 4'b0110; req = 4'b0001;
        cyc();
        chk("t5b_gnt", 32'(gnt), 32'h1);
        chk("t5b_id",  32'(gnt_id), 32'd0);
        chk("t5b_err", 32'(ptr_err), 32'd1);
        cyc();
        chk("t5b_err_off", 32'(ptr_err), 32'd0);
        req = 4'b0; cyc(); cyc();

        // Asynchronous reset in the middle of a grant.
        ptr = 4'b0001; req = 4'b0001;
        cyc(); cyc();
        @(posedge clk);
        model_step();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_gnt",   32'(gnt), 32'd0);
        chk("t6_valid", 32'(gnt_valid), 32'd0);
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
        cyc();
        chk("t6_regnt", 32'(gnt), 32'h1);
        chk("t6_to",    32'(timeout), 32'd0);
        req = 4'b0; cyc(); cyc();

        // Randomized traffic with a rotating pointer and occasional bad pointers.
        ptr = 4'b1000;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 99) < 30) req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) < 10) ptr = 4'($urandom_range(0, 15));
            else if ($countones(ptr) == 1) ptr = {ptr[0], ptr[3:1]};
            else ptr = 4'b1000;
            if (c == 300) begin
                @(posedge clk);
                model_step();
                #3 rst_n = 1'b0;
                model_reset();
                #1;
                chk("rnd_rst_gnt", 32'(gnt), 32'd0);
                @(negedge clk);
                compare_all();
                rst_n = 1'b1;
            end
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
